sync_fifo: RTL

SYNC_FIFO -- requirements
Module: sync_fifo

---
 rtl/sync_fifo.sv | 125 ++++++++++++
 1 files changed

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data, occupancy-derived status flags
// and sticky overflow/underflow error flags.
module sync_fifo #(
    parameter int DSIZE     = 8,
    parameter int ASIZE     = 4,
    parameter int AFULL_TH  = (1 << ASIZE) - 2,
    parameter int AEMPTY_TH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [DSIZE-1:0] wdata,
    input  logic             pop,
    input  logic             clr_err,
    output logic [DSIZE-1:0] rdata,
    output logic             rvalid,
    output logic             full,
    output logic             empty,
    output logic             afull,
    output logic             aempty,
    output logic [ASIZE:0]   count,
    output logic             ovf,
    output logic             udf
);

    localparam int             DEPTH    = 1 << ASIZE;
    localparam logic [ASIZE:0] DEPTH_C  = (ASIZE + 1)'(DEPTH);
    localparam logic [ASIZE:0] AFULL_C  = (ASIZE + 1)'(AFULL_TH);
    localparam logic [ASIZE:0] AEMPTY_C = (ASIZE + 1)'(AEMPTY_TH);
    localparam logic [ASIZE:0] ONE_C    = (ASIZE + 1)'(1);

    logic [DSIZE-1:0] mem_r [DEPTH];
    logic [ASIZE-1:0] wr_ptr_r;
    logic [ASIZE-1:0] rd_ptr_r;
    logic [ASIZE:0]   count_r;
    logic [DSIZE-1:0] rdata_r;
    logic             rvalid_r;
    logic             ovf_r;
    logic             udf_r;

    logic             push_ok_s;
    logic             pop_ok_s;
    logic [ASIZE:0]   count_next_s;
    logic             ovf_next_s;
    logic             udf_next_s;

    // Status flags are pure decodes of the registered occupancy
    assign empty  = (count_r == {(ASIZE + 1){1'b0}});
    assign full   = (count_r == DEPTH_C);
    assign afull  = (count_r >= AFULL_C);
    assign aempty = (count_r <= AEMPTY_C);
    assign count  = count_r;
    assign rdata  = rdata_r;
    assign rvalid = rvalid_r;
    assign ovf    = ovf_r;
    assign udf    = udf_r;

    // Acceptance decisions, next occupancy and next error-flag state
    always_comb begin
        push_ok_s    = push & ~full;
        pop_ok_s     = pop & ~empty;
        count_next_s = count_r;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_next_s = count_r + ONE_C;
            2'b01:   count_next_s = count_r - ONE_C;
            default: count_next_s = count_r;
        endcase
        // A fresh error outranks a simultaneous clear
        if (push && full) begin
            ovf_next_s = 1'b1;
        end else if (clr_err) begin
            ovf_next_s = 1'b0;
        end else begin
            ovf_next_s = ovf_r;
        end
        if (pop && empty) begin
            udf_next_s = 1'b1;
        end else if (clr_err) begin
            udf_next_s = 1'b0;
        end else begin
            udf_next_s = udf_r;
        end
    end

    // Pointers, occupancy, read data and error flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {ASIZE{1'b0}};
            rd_ptr_r <= {ASIZE{1'b0}};
            count_r  <= {(ASIZE + 1){1'b0}};
            rdata_r  <= {DSIZE{1'b0}};
            rvalid_r <= 1'b0;
            ovf_r    <= 1'b0;
            udf_r    <= 1'b0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + ASIZE'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + ASIZE'(1);
                rdata_r  <= mem_r[rd_ptr_r];
                rvalid_r <= 1'b1;
            end else begin
                rd_ptr_r <= rd_ptr_r;
                rdata_r  <= rdata_r;
                rvalid_r <= 1'b0;
            end
            count_r <= count_next_s;
            ovf_r   <= ovf_next_s;
            udf_r   <= udf_next_s;
        end
    end

    // Storage array; deliberately not reset, and gated so a reset edge writes nothing
    always_ff @(posedge clk) begin
        if (push_ok_s && !rst) begin
            mem_r[wr_ptr_r] <= wdata;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

endmodule
